// File: rtl/win_bdb_pipe_if.sv
// win_bdb_pipe_if: tile stream into the Winograd input transform, transformed tile
// stream out, plus the running count of delivered tiles.
interface win_bdb_pipe_if #(
   parameter int DW    = 16,
   parameter int OW    = 16,
   parameter int CNT_W = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic             in_last;
   logic [4*DW-1:0]  act1;
   logic [4*DW-1:0]  act2;
   logic [4*DW-1:0]  act3;
   logic [4*DW-1:0]  act4;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [4*OW-1:0]  v_tmp1;
   logic [4*OW-1:0]  v_tmp2;
   logic [4*OW-1:0]  v_tmp3;
   logic [4*OW-1:0]  v_tmp4;
   logic [CNT_W-1:0] tile_cnt;

   modport slave (
      input  in_valid, in_last, act1, act2, act3, act4, out_ready,
      output in_ready, out_valid, out_last, v_tmp1, v_tmp2, v_tmp3, v_tmp4, tile_cnt
   );

   modport master (
      output in_valid, in_last, act1, act2, act3, act4, out_ready,
      input  in_ready, out_valid, out_last, v_tmp1, v_tmp2, v_tmp3, v_tmp4, tile_cnt
   );
endinterface

// File: rtl/win_bdb_pipe.sv
// win_bdb_pipe: two-stage pipelined Winograd F(2x2,3x3) input transform V = B^T.d.B.
// Define WIN_BDB_SAT_EN to saturate (instead of wrap) outputs when OW < DW+2.
module win_bdb_pipe #(
   parameter int DW    = 16,
   parameter int OW    = 16,
   parameter int CNT_W = 16
) (
   input logic           clk,
   input logic           rst_n,
   input logic           enable,
   win_bdb_pipe_if.slave bus
);
   localparam int BW = DW + 1;
   localparam int VW = DW + 2;

`ifdef WIN_BDB_SAT_EN
   localparam logic signed [VW-1:0] SAT_MAX = (OW < VW) ? VW'((1 <<< (OW - 1)) - 1) : '0;
   localparam logic signed [VW-1:0] SAT_MIN = (OW < VW) ? VW'(-(1 <<< (OW - 1))) : '0;
`endif

   logic                 w_s1_adv;
   logic                 w_s2_adv;
   logic                 r_s1_valid;
   logic                 r_s1_last;
   logic                 r_s2_valid;
   logic                 r_s2_last;
   logic [CNT_W-1:0]     r_tile_cnt;

   logic [4*DW-1:0]      w_act [4];
   logic signed [DW-1:0] w_d   [4][4];
   logic signed [BW-1:0] w_b   [4][4];
   logic signed [BW-1:0] r_b   [4][4];
   logic signed [VW-1:0] w_vf  [4][4];
   logic [OW-1:0]        w_vn  [4][4];
   logic [OW-1:0]        r_v   [4][4];

   // A stage advances when it is empty or its content is leaving this cycle.
   assign w_s2_adv = enable & (~r_s2_valid | bus.out_ready);
   assign w_s1_adv = enable & (~r_s1_valid | w_s2_adv);

   assign w_act[0] = bus.act1;
   assign w_act[1] = bus.act2;
   assign w_act[2] = bus.act3;
   assign w_act[3] = bus.act4;

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            w_d[r][c] = w_act[r][(3-c)*DW +: DW];
         end
      end
      for (int c = 0; c < 4; c++) begin
         w_b[0][c] = BW'(w_d[0][c]) - BW'(w_d[2][c]);
         w_b[1][c] = BW'(w_d[1][c]) + BW'(w_d[2][c]);
         w_b[2][c] = BW'(w_d[2][c]) - BW'(w_d[1][c]);
         w_b[3][c] = BW'(w_d[1][c]) - BW'(w_d[3][c]);
      end
   end

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         w_vf[r][0] = VW'(r_b[r][0]) - VW'(r_b[r][2]);
         w_vf[r][1] = VW'(r_b[r][1]) + VW'(r_b[r][2]);
         w_vf[r][2] = VW'(r_b[r][2]) - VW'(r_b[r][1]);
         w_vf[r][3] = VW'(r_b[r][1]) - VW'(r_b[r][3]);
      end
   end

   // Signed size cast sign-extends for wide OW and keeps the LSBs for narrow OW.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            w_vn[r][c] = OW'(w_vf[r][c]);
`ifdef WIN_BDB_SAT_EN
            if (OW < VW) begin
               if (w_vf[r][c] > SAT_MAX) begin
                  w_vn[r][c] = OW'(SAT_MAX);
               end else if (w_vf[r][c] < SAT_MIN) begin
                  w_vn[r][c] = OW'(SAT_MIN);
               end
            end
`endif
         end
      end
   end

   // NOTE: stage-1 data has no reset; r_s1_valid qualifies it, so clearing the valid bit is enough.
   always_ff @(posedge clk) begin
      if (w_s1_adv && bus.in_valid) begin
         r_b <= w_b;
      end
   end

   // NOTE: all state uses non-blocking assignments so each stage reads its predecessor's pre-edge value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_last  <= 1'b0;
         r_tile_cnt <= '0;
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               r_v[r][c] <= '0;
            end
         end
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               r_s1_last <= bus.in_last;
            end
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_last <= r_s1_last;
               r_v       <= w_vn;
            end
         end
         if (enable && r_s2_valid && bus.out_ready) begin
            r_tile_cnt <= r_tile_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready  = w_s1_adv;
   assign bus.out_valid = r_s2_valid;
   assign bus.out_last  = r_s2_last;
   assign bus.v_tmp1    = {r_v[0][0], r_v[0][1], r_v[0][2], r_v[0][3]};
   assign bus.v_tmp2    = {r_v[1][0], r_v[1][1], r_v[1][2], r_v[1][3]};
   assign bus.v_tmp3    = {r_v[2][0], r_v[2][1], r_v[2][2], r_v[2][3]};
   assign bus.v_tmp4    = {r_v[3][0], r_v[3][1], r_v[3][2], r_v[3][3]};
   assign bus.tile_cnt  = r_tile_cnt;
endmodule

// File: tb/tb_win_bdb_pipe.sv
// tb_win_bdb_pipe: scoreboard bench for win_bdb_pipe; dut_a is 16->16 bits with a 16-bit
// counter, dut_b shares its stimulus at full precision (OW=18) with a 2-bit counter.
module tb_win_bdb_pipe;
   typedef struct packed {
      logic             last;
      logic [15:0][17:0] v;
   } exp_t;

   localparam int BT [4][4] = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b1;
   bit   armed = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;
   int   exp_cnt = 0;
   exp_t sb_q[$];
   logic signed [15:0] d [4][4];

   win_bdb_pipe_if #(.DW(16), .OW(16), .CNT_W(16)) bus_a ();
   win_bdb_pipe_if #(.DW(16), .OW(18), .CNT_W(2))  bus_b ();

   assign bus_b.in_valid  = bus_a.in_valid;
   assign bus_b.in_last   = bus_a.in_last;
   assign bus_b.act1      = bus_a.act1;
   assign bus_b.act2      = bus_a.act2;
   assign bus_b.act3      = bus_a.act3;
   assign bus_b.act4      = bus_a.act4;
   assign bus_b.out_ready = bus_a.out_ready;

   win_bdb_pipe #(.DW(16), .OW(16), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus_a));
   win_bdb_pipe #(.DW(16), .OW(18), .CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus_b));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [63:0] a1, input logic [63:0] a2,
                                  input logic [63:0] a3, input logic [63:0] a4, input logic last);
      exp_t        e;
      logic [63:0] rows [4];
      int          dd [4][4];
      int          t [4][4];
      int          acc;
      rows[0] = a1; rows[1] = a2; rows[2] = a3; rows[3] = a4;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            dd[r][c] = int'($signed(rows[r][(3-c)*16 +: 16]));
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            acc = 0;
            for (int k = 0; k < 4; k++) acc += BT[i][k] * dd[k][j];
            t[i][j] = acc;
         end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            acc = 0;
            for (int k = 0; k < 4; k++) acc += t[i][k] * BT[j][k];
            e.v[i*4+j] = 18'(acc);
         end
      e.last = last;
      return e;
   endfunction

   function automatic logic [15:0] narrow16(input int x);
`ifdef WIN_BDB_SAT_EN
      if (x > 32767) return 16'h7fff;
      if (x < -32768) return 16'h8000;
`endif
      return x[15:0];
   endfunction

   // Scoreboard: push on input acceptance, pop and compare on output transfer.
   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [63:0] ra [4];
      logic [71:0] rb [4];
      logic [63:0] prev_v [4];
      logic        prev_last;
      bit          prev_hold;
      int          full;
      if (!rst_n) begin
         sb_q.delete();
         exp_cnt   = 0;
         prev_hold = 1'b0;
      end else if (armed) begin
         ra = '{bus_a.v_tmp1, bus_a.v_tmp2, bus_a.v_tmp3, bus_a.v_tmp4};
         rb = '{bus_b.v_tmp1, bus_b.v_tmp2, bus_b.v_tmp3, bus_b.v_tmp4};
         check("tile_cnt_a", 64'(bus_a.tile_cnt), 64'(exp_cnt[15:0]));
         check("tile_cnt_b", 64'(bus_b.tile_cnt), 64'(exp_cnt[1:0]));
         if (prev_hold) begin
            check("hold_valid", 64'(bus_a.out_valid), 64'd1);
            check("hold_last", 64'(bus_a.out_last), 64'(prev_last));
            for (int r = 0; r < 4; r++)
               check($sformatf("hold_row%0d", r + 1), ra[r], prev_v[r]);
         end
         if (bus_a.out_valid && bus_a.out_ready && enable) begin
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            check("b_out_valid", 64'(bus_b.out_valid), 64'd1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               for (int r = 0; r < 4; r++)
                  for (int c = 0; c < 4; c++) begin
                     full = int'($signed(e.v[r*4+c]));
                     check($sformatf("va_r%0dc%0d", r + 1, c + 1), 64'(ra[r][(3-c)*16 +: 16]), 64'(narrow16(full)));
                     check($sformatf("vb_r%0dc%0d", r + 1, c + 1), 64'(rb[r][(3-c)*18 +: 18]), 64'(e.v[r*4+c]));
                  end
               check("out_last", 64'(bus_a.out_last), 64'(e.last));
            end
            exp_cnt++;
         end
         prev_hold = bus_a.out_valid && !(bus_a.out_ready && enable);
         prev_last = bus_a.out_last;
         prev_v    = ra;
         if (bus_a.in_valid && bus_a.in_ready)
            sb_q.push_back(model(bus_a.act1, bus_a.act2, bus_a.act3, bus_a.act4, bus_a.in_last));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_d();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) d[r][c] = '0;
   endtask

   task automatic rand_d();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) d[r][c] = 16'($urandom);
   endtask

   task automatic drive(input logic last);
      bus_a.act1     = {d[0][0], d[0][1], d[0][2], d[0][3]};
      bus_a.act2     = {d[1][0], d[1][1], d[1][2], d[1][3]};
      bus_a.act3     = {d[2][0], d[2][1], d[2][2], d[2][3]};
      bus_a.act4     = {d[3][0], d[3][1], d[3][2], d[3][3]};
      bus_a.in_last  = last;
      bus_a.in_valid = 1'b1;
   endtask

   task automatic accept();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus_a.in_ready && n < 50);
      if (!bus_a.in_ready) check("send_timeout", 64'(bus_a.in_ready), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic last);
      drive(last);
      accept();
   endtask

   task automatic idle();
      bus_a.in_valid = 1'b0;
      bus_a.in_last  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 30) begin
         step(1);
         n++;
      end
      check("drain_empty", 64'(sb_q.size()), 64'd0);
   endtask

   task automatic reset_dut();
      idle();
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bool_t_init: begin
         bus_a.in_valid  = 1'b0;
         bus_a.in_last   = 1'b0;
         bus_a.act1      = '0;
         bus_a.act2      = '0;
         bus_a.act3      = '0;
         bus_a.act4      = '0;
         bus_a.out_ready = 1'b1;
      end
      step(2);
      rst_n = 1'b1;
      armed = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
      check("rst_out_last", 64'(bus_a.out_last), 64'd0);
      check("rst_v1", 64'(bus_a.v_tmp1), 64'd0);
      check("rst_v2", 64'(bus_a.v_tmp2), 64'd0);
      check("rst_v3", 64'(bus_a.v_tmp3), 64'd0);
      check("rst_v4", 64'(bus_a.v_tmp4), 64'd0);
      check("rst_tile_cnt", 64'(bus_a.tile_cnt), 64'd0);
      check("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
      check("rst_b_in_ready", 64'(bus_b.in_ready), 64'd1);
      check("rst_b_out_last", 64'(bus_b.out_last), 64'd0);
      @(posedge clk);
      #1;

      // All ones: 2-cycle latency, only v2_2 = 4
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) d[r][c] = 16'sd1;
      send(1'b0);
      idle();
      @(negedge clk);
      check("t1_lat1_valid", 64'(bus_a.out_valid), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t1_lat2_valid", 64'(bus_a.out_valid), 64'd1);
      check("t1_v22", 64'(bus_a.v_tmp2[32 +: 16]), 64'd4);
      check("t1_v11", 64'(bus_a.v_tmp1[48 +: 16]), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t1_tile_cnt", 64'(bus_a.tile_cnt), 64'd1);
      @(posedge clk);
      #1;

      // Impulses
      clear_d();
      d[0][0] = 16'sd1;
      send(1'b0);
      clear_d();
      d[2][2] = -16'sd1;
      send(1'b1);
      idle();
      drain();

      // Overflow: four 0x7FFF in the centre
      clear_d();
      d[1][1] = 16'sh7fff; d[1][2] = 16'sh7fff; d[2][1] = 16'sh7fff; d[2][2] = 16'sh7fff;
      send(1'b0);
      idle();
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("ovf_valid", 64'(bus_a.out_valid), 64'd1);
`ifdef WIN_BDB_SAT_EN
      check("ovf_v22_ow16", 64'(bus_a.v_tmp2[32 +: 16]), 64'h7fff);
`else
      check("ovf_v22_ow16", 64'(bus_a.v_tmp2[32 +: 16]), 64'hfffc);
`endif
      check("ovf_v22_ow18", 64'(bus_b.v_tmp2[36 +: 18]), 64'd131068);
      @(posedge clk);
      #1;
      drain();

      // Backpressure: five tiles, out_ready low for four cycles
      reset_dut();
      bus_a.out_ready = 1'b0;
      rand_d();
      send(1'b0);
      rand_d();
      drive(1'b0);
      @(negedge clk);
      check("bp_ready_s1_full", 64'(bus_a.in_ready), 64'd1);
      @(posedge clk);
      #1;
      rand_d();
      drive(1'b0);
      @(negedge clk);
      check("bp_ready_both_full", 64'(bus_a.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus_a.out_valid), 64'd1);
      step(3);
      bus_a.out_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_shift", 64'(bus_a.in_ready), 64'd1);
      @(posedge clk);
      #1;
      rand_d();
      send(1'b0);
      rand_d();
      send(1'b1);
      idle();
      drain();
      check("bp_tile_cnt", 64'(bus_a.tile_cnt), 64'd5);

      // enable low for three cycles with tiles in flight
      reset_dut();
      rand_d();
      send(1'b0);
      rand_d();
      send(1'b1);
      enable = 1'b0;
      rand_d();
      drive(1'b0);
      repeat (3) begin
         @(negedge clk);
         check("en_in_ready", 64'(bus_a.in_ready), 64'd0);
         check("en_out_valid", 64'(bus_a.out_valid), 64'd1);
         check("en_tile_cnt", 64'(bus_a.tile_cnt), 64'd0);
         @(posedge clk);
         #1;
      end
      enable = 1'b1;
      accept();
      idle();
      drain();
      check("en_tile_cnt_end", 64'(bus_a.tile_cnt), 64'd3);

      // Reset with two tiles in flight
      reset_dut();
      rand_d();
      send(1'b0);
      rand_d();
      send(1'b0);
      reset_dut();
      @(negedge clk);
      check("mrst_out_valid", 64'(bus_a.out_valid), 64'd0);
      check("mrst_tile_cnt", 64'(bus_a.tile_cnt), 64'd0);
      repeat (4) begin
         @(negedge clk);
         check("mrst_no_stale", 64'(bus_a.out_valid), 64'd0);
      end
      @(posedge clk);
      #1;

      // Counter wrap on the 2-bit instance
      reset_dut();
      repeat (4) begin
         rand_d();
         send(1'b0);
      end
      idle();
      drain();
      check("wrap_cnt_b", 64'(bus_b.tile_cnt), 64'd0);
      check("wrap_cnt_a", 64'(bus_a.tile_cnt), 64'd4);

      // Random traffic with random backpressure
      begin
         bit took = 1'b1;
         for (int i = 0; i < 40; i++) begin
            bus_a.out_ready = 1'($urandom_range(0, 1));
            if (!bus_a.in_valid || took) begin
               rand_d();
               drive(1'($urandom_range(0, 1)));
               bus_a.in_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            took = bus_a.in_valid && bus_a.in_ready;
            @(posedge clk);
            #1;
         end
      end
      idle();
      bus_a.out_ready = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
